// File: rtl/lsu_access_seq.sv
// Load/store sequencer between the MEM stage and dmemory: registers one request,
// splits misaligned halfword/word accesses into byte accesses and returns extended load data.
module lsu_access_seq #(
    parameter bit          ALLOW_MISALIGNED = 1'b1,
    parameter int unsigned ADDR_W           = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic              req_write,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic [1:0]        mem_accsize,
    output logic              mem_un,
    output logic              mem_wen,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, SINGLE, BYTES, DONE} state_t;

    state_t            state, state_nx;
    logic              ready_en;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       acc;
    logic [1:0]        r_size;
    logic [1:0]        cnt;
    logic [1:0]        cnt_nx;
    logic              r_un;
    logic              r_write;
    logic              r_err;
    logic              misaligned;
    logic              accept;
    logic              last_byte;
    logic [31:0]       ext;

    always_comb begin
        misaligned = 1'b0;
        if (req_size == 2'd1)
            misaligned = req_addr[0];
        else if (req_size[1])
            misaligned = |req_addr[1:0];
        // ready is held off for the first cycle after reset release
        req_ready = ready_en && (state == IDLE);
        accept    = req_valid && req_ready;
        last_byte = (cnt == ((r_size == 2'd1) ? 2'd1 : 2'd3));
        cnt_nx    = cnt + 2'd1;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!misaligned)
                        state_nx = SINGLE;
                    else if (ALLOW_MISALIGNED)
                        state_nx = BYTES;
                    else
                        state_nx = DONE;
                end
            end
            SINGLE: state_nx = DONE;
            BYTES:  if (last_byte) state_nx = DONE;
            DONE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ext = acc;
        case (r_size)
            2'd0: ext = r_un ? {24'b0, acc[7:0]}  : {{24{acc[7]}}, acc[7:0]};
            2'd1: ext = r_un ? {16'b0, acc[15:0]} : {{16{acc[15]}}, acc[15:0]};
            default: ext = acc;
        endcase
        resp_valid = (state == DONE);
        resp_err   = (state == DONE) && r_err;
        resp_rdata = ((state == DONE) && !r_err && !r_write) ? ext : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            ready_en    <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_size      <= '0;
            r_un        <= 1'b0;
            r_write     <= 1'b0;
            r_err       <= 1'b0;
            cnt         <= '0;
            acc         <= '0;
            mem_addr    <= '0;
            mem_data    <= '0;
            mem_accsize <= '0;
            mem_un      <= 1'b0;
            mem_wen     <= 1'b0;
        end else begin
            state    <= state_nx;
            ready_en <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_size  <= req_size;
                        r_un    <= req_unsigned;
                        r_write <= req_write;
                        r_err   <= misaligned && !ALLOW_MISALIGNED;
                        cnt     <= '0;
                        acc     <= '0;
                        // memory drive is set up here so it is valid throughout the first access cycle
                        if (!misaligned) begin
                            mem_addr    <= req_addr;
                            mem_accsize <= req_size;
                            mem_un      <= req_unsigned;
                            mem_wen     <= req_write;
                            mem_data    <= req_wdata;
                        end else if (ALLOW_MISALIGNED) begin
                            mem_addr    <= req_addr;
                            mem_accsize <= 2'd0;
                            mem_un      <= 1'b1;
                            mem_wen     <= req_write;
                            mem_data    <= {24'b0, req_wdata[7:0]};
                        end
                    end
                end
                SINGLE: begin
                    if (!r_write)
                        acc <= mem_rdata;
                    mem_wen <= 1'b0;
                end
                BYTES: begin
                    if (!r_write)
                        acc[8*cnt +: 8] <= mem_rdata[7:0];
                    cnt <= cnt_nx;
                    if (last_byte) begin
                        mem_wen <= 1'b0;
                    end else begin
                        mem_addr <= r_addr + ADDR_W'(cnt_nx);
                        mem_data <= {24'b0, r_wdata[8*cnt_nx +: 8]};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_access_seq.sv
// Directed bench for lsu_access_seq with a byte-array dmemory model and a
// second instance built with misaligned accesses rejected.
module tb_lsu_access_seq;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_valid2 = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic        req_write = 1'b0;

    logic        req_ready, resp_valid, resp_err, mem_un, mem_wen;
    logic [31:0] resp_rdata, mem_addr, mem_data, mem_rdata;
    logic [1:0]  mem_accsize;

    logic        nm_ready, nm_resp_valid, nm_err, nm_un, nm_wen;
    logic [31:0] nm_rdata, nm_addr, nm_data;
    logic [1:0]  nm_accsize;
    logic        nm_wen_seen = 1'b0;

    logic [7:0]  m [0:4095];
    logic [11:0] ia;
    logic        pre_en = 1'b0;
    logic [11:0] pre_a = '0;
    logic [7:0]  pre_d = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    lsu_access_seq #(.ALLOW_MISALIGNED(1'b1), .ADDR_W(32)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_write(req_write), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_accsize(mem_accsize), .mem_un(mem_un), .mem_wen(mem_wen),
        .mem_rdata(mem_rdata)
    );

    lsu_access_seq #(.ALLOW_MISALIGNED(1'b0), .ADDR_W(32)) dut_nm (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid2), .req_ready(nm_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_write(req_write), .resp_valid(nm_resp_valid), .resp_rdata(nm_rdata),
        .resp_err(nm_err), .mem_addr(nm_addr), .mem_data(nm_data),
        .mem_accsize(nm_accsize), .mem_un(nm_un), .mem_wen(nm_wen),
        .mem_rdata(32'h0)
    );

    // dmemory model: combinational little-endian read, sized write on the clock edge
    always_comb begin
        ia        = mem_addr[11:0];
        mem_rdata = {m[ia + 12'd3], m[ia + 12'd2], m[ia + 12'd1], m[ia]};
    end

    always @(posedge clock) begin
        if (pre_en) begin
            m[pre_a] <= pre_d;
        end else if (mem_wen) begin
            m[ia] <= mem_data[7:0];
            if (mem_accsize != 2'd0) m[ia + 12'd1] <= mem_data[15:8];
            if (mem_accsize[1]) begin
                m[ia + 12'd2] <= mem_data[23:16];
                m[ia + 12'd3] <= mem_data[31:24];
            end
        end
        if (nm_wen) nm_wen_seen <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic preset(input logic [11:0] a, input logic [7:0] d);
        pre_a  = a;
        pre_d  = d;
        pre_en = 1'b1;
        step();
        pre_en = 1'b0;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz,
                         input logic un, input logic wr);
        req_addr     = a;
        req_wdata    = wd;
        req_size     = sz;
        req_unsigned = un;
        req_write    = wr;
        req_valid    = 1'b1;
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] wrap_a [4];
        logic [31:0] bexp [3];
        wrap_a = '{32'hFFFF_FFFF, 32'h0, 32'h1, 32'h2};
        bexp   = '{32'h80, 32'h7F, 32'hFF};

        // reset values
        step();
        step();
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_mem_wen", mem_wen, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_mem_accsize", mem_accsize, 0);
        chk("rst_mem_un", mem_un, 0);
        chk("rst_ready", req_ready, 0);
        reset_n = 1'b1;
        #1;
        chk("rel_ready_early", req_ready, 0);
        step();
        chk("rel_ready", req_ready, 1);

        // aligned LW
        preset(12'h100, 8'hBB); preset(12'h101, 8'hAA);
        preset(12'h102, 8'h99); preset(12'h103, 8'h88);
        issue(32'h100, 32'h0, 2'd2, 1'b0, 1'b0);
        step();
        req_valid = 1'b0;
        chk("lw_c1_addr", mem_addr, 32'h100);
        chk("lw_c1_accsize", mem_accsize, 2);
        chk("lw_c1_wen", mem_wen, 0);
        chk("lw_c1_valid", resp_valid, 0);
        step();
        chk("lw_c2_valid", resp_valid, 1);
        chk("lw_c2_rdata", resp_rdata, 32'h8899AABB);
        chk("lw_c2_ready", req_ready, 0);
        step();
        chk("lw_c3_valid", resp_valid, 0);
        chk("lw_c3_ready", req_ready, 1);

        // misaligned LH, signed then unsigned; req_addr changes mid-operation
        preset(12'h101, 8'h34); preset(12'h102, 8'hF2);
        issue(32'h101, 32'h0, 2'd1, 1'b0, 1'b0);
        step();
        req_valid = 1'b0;
        req_addr  = 32'h555;
        chk("lh_c1_addr", mem_addr, 32'h101);
        chk("lh_c1_accsize", mem_accsize, 0);
        chk("lh_c1_un", mem_un, 1);
        step();
        chk("lh_c2_addr", mem_addr, 32'h102);
        chk("lh_c2_valid", resp_valid, 0);
        step();
        chk("lh_c3_valid", resp_valid, 1);
        chk("lh_c3_rdata", resp_rdata, 32'hFFFFF234);
        step();
        issue(32'h101, 32'h0, 2'd1, 1'b1, 1'b0);
        step();
        req_valid = 1'b0;
        step();
        step();
        chk("lhu_c3_valid", resp_valid, 1);
        chk("lhu_c3_rdata", resp_rdata, 32'h0000F234);
        step();

        // misaligned SW split into four byte writes
        preset(12'h207, 8'h00);
        w = 32'hDEADBEEF;
        issue(32'h203, w, 2'd2, 1'b0, 1'b1);
        step();
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("sw_addr", mem_addr, 32'h203 + 32'(k));
            chk("sw_wen", mem_wen, 1);
            chk("sw_data", mem_data, {24'b0, w[8*k +: 8]});
            chk("sw_accsize", mem_accsize, 0);
            step();
        end
        chk("sw_valid", resp_valid, 1);
        chk("sw_rdata", resp_rdata, 0);
        chk("sw_done_wen", mem_wen, 0);
        step();
        issue(32'h204, 32'h0, 2'd2, 1'b0, 1'b0);
        step();
        req_valid = 1'b0;
        step();
        chk("sw_readback_valid", resp_valid, 1);
        chk("sw_readback", resp_rdata, 32'h00DEADBE);
        step();

        // misaligned word load wrapping past the top of the address space
        preset(12'hFFF, 8'h11); preset(12'h000, 8'h22);
        preset(12'h001, 8'h33); preset(12'h002, 8'h44);
        issue(32'hFFFF_FFFF, 32'h0, 2'd3, 1'b0, 1'b0);
        step();
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("wrap_addr", mem_addr, wrap_a[k]);
            step();
        end
        chk("wrap_valid", resp_valid, 1);
        chk("wrap_rdata", resp_rdata, 32'h44332211);
        step();

        // rejecting instance: misaligned LW
        issue(32'h2, 32'h0, 2'd2, 1'b0, 1'b0);
        req_valid  = 1'b0;
        req_valid2 = 1'b1;
        step();
        req_valid2 = 1'b0;
        chk("nm_valid", nm_resp_valid, 1);
        chk("nm_err", nm_err, 1);
        chk("nm_rdata", nm_rdata, 0);
        chk("nm_main_idle", resp_valid, 0);
        step();
        chk("nm_valid_after", nm_resp_valid, 0);
        chk("nm_ready_after", nm_ready, 1);

        // reset during the second byte of a misaligned SW
        preset(12'h301, 8'h00); preset(12'h302, 8'h00);
        issue(32'h301, 32'h11223344, 2'd2, 1'b0, 1'b1);
        step();
        req_valid = 1'b0;
        chk("rsw_c1_addr", mem_addr, 32'h301);
        chk("rsw_c1_wen", mem_wen, 1);
        chk("rsw_c1_data", mem_data, 32'h44);
        step();
        chk("rsw_c2_addr", mem_addr, 32'h302);
        chk("rsw_c2_wen", mem_wen, 1);
        reset_n = 1'b0;
        #1;
        chk("rsw_rst_wen", mem_wen, 0);
        chk("rsw_rst_valid", resp_valid, 0);
        step();
        chk("rsw_rst_valid2", resp_valid, 0);
        step();
        reset_n = 1'b1;
        step();
        chk("rsw_ready", req_ready, 1);
        chk("rsw_no_resp", resp_valid, 0);
        chk("rsw_byte0", m[12'h301], 8'h44);
        chk("rsw_byte1", m[12'h302], 8'h00);

        // back-to-back aligned LBU with req_valid held high
        preset(12'h400, 8'h80); preset(12'h401, 8'h7F); preset(12'h402, 8'hFF);
        issue(32'h400, 32'h0, 2'd0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            chk("b2b_ready", req_ready, 32'(i % 3 == 0));
            chk("b2b_valid", resp_valid, 32'(i % 3 == 2));
            if (i % 3 == 2) chk("b2b_rdata", resp_rdata, bexp[i / 3]);
            if (i % 3 == 0) req_addr = 32'h400 + 32'(i / 3);
            step();
        end
        chk("b2b_end_ready", req_ready, 1);
        req_valid = 1'b0;
        step();
        chk("b2b_end_idle", resp_valid, 0);

        chk("nm_wen_never", nm_wen_seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
